// File: rtl/button_debouncer_multi.sv
// Purpose: N-channel push-button conditioner with press/release/long pulses; auto-repeat only when BTN_AUTO_REPEAT_EN is defined.
// Latency: press/release reported DEBOUNCE_CYCLES+2 edges after btn_in settles; every output is registered.
// Backpressure: none; pulses are single-cycle and unconditional.
module button_debouncer_multi #(
    parameter int N_CH            = 5,
    parameter int DEBOUNCE_CYCLES = 524288,
    parameter int LONG_CYCLES     = 134217727,
    parameter int REPEAT_CYCLES   = 16777216,
    parameter int CNT_W           = $clog2(LONG_CYCLES + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] level_out,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_pulse,
    output logic [N_CH-1:0] repeat_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } state_t;

    // Counters fire on the edge where they would reach the target, hence the "last" values.
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(LONG_CYCLES);

    // Elaborates to nothing; keeps every parameter referenced in the default build.
    if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_cfg_invalid
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic             sync1_q, sync2_q;
        state_t           state_q, state_d;
        logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
        logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
        logic             level_q, level_d;
        logic             press_q, press_d;
        logic             rel_q, rel_d;
        logic             long_q, long_d;
        logic             rel_hit;
`ifdef BTN_AUTO_REPEAT_EN
        localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
        logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
        logic             rep_q, rep_d;
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                sync1_q    <= 1'b0;
                sync2_q    <= 1'b0;
                state_q    <= ST_IDLE;
                deb_cnt_q  <= '0;
                hold_cnt_q <= '0;
                level_q    <= 1'b0;
                press_q    <= 1'b0;
                rel_q      <= 1'b0;
                long_q     <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
                rep_cnt_q  <= '0;
                rep_q      <= 1'b0;
`endif
            end else begin
                sync1_q    <= btn_in[g];
                sync2_q    <= sync1_q;
                state_q    <= state_d;
                deb_cnt_q  <= deb_cnt_d;
                hold_cnt_q <= hold_cnt_d;
                level_q    <= level_d;
                press_q    <= press_d;
                rel_q      <= rel_d;
                long_q     <= long_d;
`ifdef BTN_AUTO_REPEAT_EN
                rep_cnt_q  <= rep_cnt_d;
                rep_q      <= rep_d;
`endif
            end
        end

        always_comb begin
            state_d    = state_q;
            deb_cnt_d  = deb_cnt_q;
            hold_cnt_d = hold_cnt_q;
            level_d    = level_q;
            press_d    = 1'b0;
            rel_d      = 1'b0;
            long_d     = 1'b0;
            rel_hit    = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
            rep_cnt_d  = rep_cnt_q;
            rep_d      = 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    level_d = 1'b0;
                    if (!sync2_q) begin
                        deb_cnt_d = '0;
                    end else if (deb_cnt_q == DEB_LAST) begin
                        state_d    = ST_PRESSED;
                        press_d    = 1'b1;
                        level_d    = 1'b1;
                        hold_cnt_d = '0;
                        deb_cnt_d  = '0;
                    end else begin
                        deb_cnt_d = deb_cnt_q + 1'b1;
                    end
                end
                ST_PRESSED, ST_LONG: begin
                    level_d   = 1'b1;
                    rel_hit   = !sync2_q && (deb_cnt_q == DEB_LAST);
                    deb_cnt_d = sync2_q ? '0 : deb_cnt_q + 1'b1;
                    if (state_q == ST_PRESSED) begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                    // Release outranks both long detection and a due repeat.
                    if (rel_hit) begin
                        state_d   = ST_IDLE;
                        rel_d     = 1'b1;
                        level_d   = 1'b0;
                        deb_cnt_d = '0;
                    end else if (state_q == ST_PRESSED && hold_cnt_q == HOLD_LAST) begin
                        state_d    = ST_LONG;
                        long_d     = 1'b1;
                        hold_cnt_d = HOLD_SAT;
`ifdef BTN_AUTO_REPEAT_EN
                        rep_cnt_d  = '0;
`endif
                    end else if (state_q == ST_LONG) begin
`ifdef BTN_AUTO_REPEAT_EN
                        if (rep_cnt_q == REP_LAST) begin
                            rep_d     = 1'b1;
                            rep_cnt_d = '0;
                        end else begin
                            rep_cnt_d = rep_cnt_q + 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        assign level_out[g]     = level_q;
        assign press_pulse[g]   = press_q;
        assign release_pulse[g] = rel_q;
        assign long_pulse[g]    = long_q;
`ifdef BTN_AUTO_REPEAT_EN
        assign repeat_pulse[g]  = rep_q;
`else
        assign repeat_pulse[g]  = 1'b0;
`endif
    end

endmodule

// File: tb/tb_button_debouncer_multi.sv
// Bench for button_debouncer_multi: directed scenarios plus random hold/bounce runs,
// checked every cycle against a window/timestamp reference model.
module tb_button_debouncer_multi;
    localparam int D    = 4;
    localparam int L    = 20;
    localparam int R    = 8;
    localparam int MAXS = 4096;
`ifdef BTN_AUTO_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] btn_in;
    logic [1:0] level_out, press_pulse, release_pulse, long_pulse, repeat_pulse;

    button_debouncer_multi #(
        .N_CH(2), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .REPEAT_CYCLES(R)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in),
        .level_out(level_out), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .long_pulse(long_pulse), .repeat_pulse(repeat_pulse)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;
    int cyc = 0;
    int rbase = 0;
    logic [1:0] bhist [0:MAXS-1];

    // Reference model state: pressed flag, press timestamp, long flag, long timestamp.
    bit m_pr [2];
    bit m_lg [2];
    int t_pr [2];
    int t_lg [2];

    // Observed-event bookkeeping for scenario checks.
    int n_pr [2];
    int n_rl [2];
    int n_lg [2];
    int n_rp [2];
    int last_pr [2];
    int last_rl [2];
    int last_lg [2];
    int rp_q1 [$];

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic bit s_at(int ch, int k);
        if (k - 2 < rbase) return 1'b0;
        return bhist[k-2][ch];
    endfunction

    // True when the last D synchronised samples of a channel all equal v.
    function automatic bit win(int ch, int k, bit v);
        for (int i = 0; i < D; i++) begin
            if (k - i < rbase) return 1'b0;
            if (s_at(ch, k - i) != v) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic clr_cnt();
        for (int c = 0; c < 2; c++) begin
            n_pr[c] = 0; n_rl[c] = 0; n_lg[c] = 0; n_rp[c] = 0;
            last_pr[c] = -1; last_rl[c] = -1; last_lg[c] = -1;
        end
        rp_q1.delete();
    endtask

    task automatic rst_step(input logic [1:0] b);
        @(negedge clk);
        rst = 1'b1;
        btn_in = b;
        @(posedge clk);
        for (int c = 0; c < 2; c++) begin
            m_pr[c] = 1'b0;
            m_lg[c] = 1'b0;
        end
        #1;
        check("rst_level", level_out, 2'b00);
        check("rst_press", press_pulse, 2'b00);
        check("rst_release", release_pulse, 2'b00);
        check("rst_long", long_pulse, 2'b00);
        check("rst_repeat", repeat_pulse, 2'b00);
        cyc++;
        rbase = cyc;
    endtask

    task automatic step(input logic [1:0] b);
        logic [1:0] e_lvl, e_pr, e_rl, e_lg, e_rp;
        @(negedge clk);
        rst = 1'b0;
        btn_in = b;
        @(posedge clk);
        bhist[cyc] = b;
        e_lvl = '0; e_pr = '0; e_rl = '0; e_lg = '0; e_rp = '0;
        for (int c = 0; c < 2; c++) begin
            if (!m_pr[c]) begin
                if (win(c, cyc, 1'b1)) begin
                    m_pr[c] = 1'b1; m_lg[c] = 1'b0; t_pr[c] = cyc; e_pr[c] = 1'b1;
                end
            end else if (win(c, cyc, 1'b0)) begin
                m_pr[c] = 1'b0; e_rl[c] = 1'b1;
            end else if (!m_lg[c] && (cyc - t_pr[c] == L)) begin
                m_lg[c] = 1'b1; t_lg[c] = cyc; e_lg[c] = 1'b1;
            end else if (m_lg[c] && REP_ON && ((cyc - t_lg[c]) % R == 0)) begin
                e_rp[c] = 1'b1;
            end
            e_lvl[c] = m_pr[c];
        end
        #1;
        check("level", level_out, e_lvl);
        check("press", press_pulse, e_pr);
        check("release", release_pulse, e_rl);
        check("long", long_pulse, e_lg);
        check("repeat", repeat_pulse, e_rp);
        for (int c = 0; c < 2; c++) begin
            if (press_pulse[c])   begin n_pr[c]++; last_pr[c] = cyc; end
            if (release_pulse[c]) begin n_rl[c]++; last_rl[c] = cyc; end
            if (long_pulse[c])    begin n_lg[c]++; last_lg[c] = cyc; end
            if (repeat_pulse[c])  begin n_rp[c]++; if (c == 1) rp_q1.push_back(cyc); end
        end
        cyc++;
    endtask

    initial begin
        int j;
        int k;
        logic [1:0] rb;
        int runleft [2];

        rst = 1'b1;
        btn_in = 2'b00;
        clr_cnt();

        // Reset with both buttons held, then release reset.
        for (int i = 0; i < 3; i++) rst_step(2'b11);
        for (int i = 0; i < 6; i++) step(2'b11);
        check_int("first_press_ch0", last_pr[0], rbase + 5);
        check_int("first_press_ch1", last_pr[1], rbase + 5);
        for (int i = 0; i < 12; i++) step(2'b00);

        // Bounce 1,1,1,0 never debounces; a clean hold then does.
        clr_cnt();
        for (int i = 0; i < 40; i++) step({1'b0, (i % 4) != 3});
        check_int("bounce_no_press", n_pr[0], 0);
        check("bounce_level", level_out, 2'b00);
        for (int i = 0; i < 6; i++) step(2'b01);
        check_int("bounce_then_press", n_pr[0], 1);
        for (int i = 0; i < 10; i++) step(2'b00);

        // Short press.
        clr_cnt();
        for (int i = 0; i < 10; i++) step(2'b01);
        for (int i = 0; i < 10; i++) step(2'b00);
        check_int("short_press", n_pr[0], 1);
        check_int("short_release", n_rl[0], 1);
        check_int("short_no_long", n_lg[0], 0);

        // Long hold on ch1 with repeats; the repeat due at release is suppressed.
        clr_cnt();
        j = cyc;
        for (int i = 0; i < 60; i++) step(2'b10);
        for (int i = 0; i < 10; i++) step(2'b00);
        check_int("long_press_lat", last_pr[1], j + 5);
        check_int("long_after_press", last_lg[1] - last_pr[1], L);
        check_int("repeat_count", n_rp[1], REP_ON ? 4 : 0);
`ifdef BTN_AUTO_REPEAT_EN
        check_int("repeat_first", rp_q1.size() > 0 ? rp_q1[0] - last_lg[1] : -1, R);
        check_int("repeat_second", rp_q1.size() > 1 ? rp_q1[1] - last_lg[1] : -1, 2 * R);
`endif
        check_int("long_release_lat", last_rl[1], j + 60 + 5);

        // Two-cycle low glitch around hold_cnt=10 does not disturb the hold.
        clr_cnt();
        for (int i = 0; i < 40; i++) step({1'b0, !(i == 13 || i == 14)});
        check_int("glitch_no_release", n_rl[0], 0);
        check_int("glitch_long_time", last_lg[0] - last_pr[0], L);
        for (int i = 0; i < 10; i++) step(2'b00);
        check_int("glitch_release", n_rl[0], 1);

        // Release debounce completing on the long edge wins.
        clr_cnt();
        for (int i = 0; i < 20; i++) step(2'b01);
        for (int i = 0; i < 10; i++) step(2'b00);
        check_int("prio_no_long", n_lg[0], 0);
        check_int("prio_release", n_rl[0], 1);
        check_int("prio_rel_time", last_rl[0] - last_pr[0], L);

        // ch0 press and ch1 release land on the same edge.
        clr_cnt();
        for (int i = 0; i < 12; i++) step(2'b10);
        k = cyc;
        for (int i = 0; i < 8; i++) step(2'b01);
        check_int("simul_press_ch0", last_pr[0], k + 5);
        check_int("simul_release_ch1", last_rl[1], k + 5);
        for (int i = 0; i < 10; i++) step(2'b00);

        // Reset mid-press aborts silently.
        clr_cnt();
        for (int i = 0; i < 8; i++) step(2'b01);
        rst_step(2'b01);
        for (int i = 0; i < 10; i++) step(2'b00);
        check_int("rst_abort_no_release", n_rl[0], 0);

        // Random runs of held levels, mixing bounces, short and long holds.
        clr_cnt();
        runleft[0] = 0;
        runleft[1] = 0;
        rb = 2'b00;
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < 2; c++) begin
                if (runleft[c] == 0) begin
                    rb[c] = ~rb[c];
                    runleft[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 45))
                                                             : int'($urandom_range(1, 8));
                end
                runleft[c]--;
            end
            step(rb);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
